shim_trigger_seq: RTL and testbench
===================================

SHIM_TRIGGER_SEQ -- requirements
Module: shim_trigger_seq

Interface
REQ-001 SHALL have parameter N_DAC, default 8, meaning DAC channel count, legal 1..8.
REQ-002 SHALL have parameter N_ADC, default 8, meaning ADC channel count, legal 1..8.
REQ-003 SHALL have parameter TIMER_WIDTH, default 64, meaning trigger timer width, legal 33..64.
REQ-004 SHALL have parameter LOCKOUT_DEFAULT, default 5000, meaning post-trigger lockout in cycles after reset.
REQ-005 SHALL have parameter LOCKOUT_MIN, default 4, meaning smallest legal SET_LOCKOUT value.
REQ-006 SHALL have ports: clk in 1 clock; resetn in 1, synchronous, active-low; cmd_word_rd_en out 1; cmd_word in 32; cmd_buf_empty in 1; data_word_wr_en out 1; data_word out 32; data_buf_full in 1; data_buf_almost_full in 1 (fewer than 2 entries free); ext_trig in 1; dac_waiting_for_trig in N_DAC; adc_waiting_for_trig in N_ADC; trig_out out 1; trig_count out 32; data_buf_overflow out 1; bad_cmd out 1.

Function
REQ-007 SHALL decode cmd_word[31:29] as opcode and [28:0] as val: 1 SYNC_CH, 2 SET_LOCKOUT, 3 EXPECT_EXT_TRIG, 4 DELAY, 5 FORCE_TRIG, 6 SET_MASK, 7 CANCEL, 0 illegal.
REQ-008 SHALL implement states IDLE, SYNC, EXPECT, DELAY, ERROR; reset state IDLE.
REQ-009 SHALL consume a command (cmd_word_rd_en=1 for one cycle, combinational with the cmd_word it accepts) when FIFO non-empty and: state IDLE; or SYNC completing; or EXPECT with remaining count 0; or DELAY with counter 0; or opcode CANCEL in any state except ERROR.
REQ-010 SHALL route on consume: CANCEL, FORCE_TRIG, SET_MASK -> IDLE; SET_LOCKOUT val>=LOCKOUT_MIN -> IDLE, else ERROR; SYNC_CH -> IDLE if all_waiting that cycle else SYNC; EXPECT_EXT_TRIG/DELAY -> IDLE if val=0 else EXPECT/DELAY; opcode 0 -> ERROR.
REQ-011 SHALL compute all_waiting as AND over DAC channels of (waiting OR NOT dac_mask[i]) AND same over ADC channels with adc_mask.
REQ-012 SHALL load dac_mask from val[N_DAC-1:0] and adc_mask from val[8+N_ADC-1:8] on SET_MASK; a mask of all zeros in both SHALL make all_waiting constantly 1; masks reset to all ones.
REQ-013 SHALL assert internal do_trig on: FORCE_TRIG consume; SYNC_CH consume with all_waiting; state SYNC with all_waiting; state EXPECT with lockout counter 0 and ext_trig qualified per REQ-027.
REQ-014 SHALL drive trig_out registered, equal to do_trig one cycle later, forced 0 on cancel or in ERROR.
REQ-015 SHALL in EXPECT decrement remaining count per do_trig; load lockout counter with current lockout on each such trigger; lockout counts down to 0 in every state.
REQ-016 SHALL in DELAY decrement delay counter once per cycle; DELAY of N exits after N cycles in DELAY.
REQ-017 SHALL on CANCEL clear remaining trigger count and delay counter, not lockout counter, not masks, not lockout value.
REQ-018 SHALL hold ERROR until reset, ignoring all commands including CANCEL; bad_cmd set sticky on entry.
REQ-019 SHALL run trig_timer (TIMER_WIDTH bits) at 0 until first do_trig, then 1 next cycle, incrementing each cycle, saturating at all ones.
REQ-020 SHALL increment trig_count (32-bit, wrapping at 2^32) on each do_trig.
REQ-021 SHALL on do_trig with neither full nor almost_full write two consecutive words: cycle+1 timer[31:0], cycle+2 timer[TIMER_WIDTH-1:32] zero-extended, timer sampled at do_trig.
REQ-022 SHALL ignore new do_trig data writes while a two-word write is in progress (trigger pulse still issued, trig_count still increments).
REQ-023 SHALL on do_trig with full or almost_full skip the write and set data_buf_overflow sticky.

Reset
REQ-024 SHALL on resetn=0 clear state to IDLE; all outputs 0; counters, timer, trig_count 0; lockout value LOCKOUT_DEFAULT; masks all ones.
REQ-025 SHALL abort any in-progress two-word write on reset; no partial second word afterwards.

Configuration
REQ-026 SHALL provide macro SHIM_TRIG_EDGE_DETECT_EN.
REQ-027 SHALL, with macro defined, qualify ext_trig as a rising edge (ext_trig=1, previous-cycle ext_trig=0, history register reset 0); without it, qualify as level-high.

Verification
REQ-028 SHALL cover: SET_MASK 0x0000_0103 with N_DAC=N_ADC=8, DAC0/DAC1/ADC0 waiting, SYNC_CH -> trig_out 1 cycle after SYNC_CH consume, trig_count=1.
REQ-029 SHALL cover: SET_LOCKOUT 10, EXPECT_EXT_TRIG 2, ext_trig held high -> triggers 11 cycles apart (level mode), state IDLE after second.
REQ-030 SHALL cover: SET_LOCKOUT 3 -> bad_cmd=1, ERROR, subsequent CANCEL not consumed.
REQ-031 SHALL cover: DELAY 100 then FORCE_TRIG -> FORCE_TRIG consumed 100 cycles after DELAY consume; CANCEL mid-delay -> immediate IDLE.
REQ-032 SHALL cover: FORCE_TRIG with almost_full=1 -> trig_out=1, no wr_en, data_buf_overflow=1; TIMER_WIDTH=40 second word upper 24 bits 0.

Source files
------------

// File: rtl/shim_trigger_seq.sv
// Trigger sequencer: consumes shim commands, issues sync/external/forced triggers and logs a timestamp per trigger.
// Optional macro SHIM_TRIG_EDGE_DETECT_EN qualifies ext_trig on its rising edge instead of its level.
module shim_trigger_seq #(
  parameter int N_DAC           = 8,
  parameter int N_ADC           = 8,
  parameter int TIMER_WIDTH     = 64,
  parameter int LOCKOUT_DEFAULT = 5000,
  parameter int LOCKOUT_MIN     = 4
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             cmd_word_rd_en,
  input  logic [31:0]      cmd_word,
  input  logic             cmd_buf_empty,
  output logic             data_word_wr_en,
  output logic [31:0]      data_word,
  input  logic             data_buf_full,
  input  logic             data_buf_almost_full,
  input  logic             ext_trig,
  input  logic [N_DAC-1:0] dac_waiting_for_trig,
  input  logic [N_ADC-1:0] adc_waiting_for_trig,
  output logic             trig_out,
  output logic [31:0]      trig_count,
  output logic             data_buf_overflow,
  output logic             bad_cmd
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_EXPECT, ST_DELAY, ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    OP_ILLEGAL     = 3'd0,
    OP_SYNC_CH     = 3'd1,
    OP_SET_LOCKOUT = 3'd2,
    OP_EXPECT_EXT  = 3'd3,
    OP_DELAY       = 3'd4,
    OP_FORCE_TRIG  = 3'd5,
    OP_SET_MASK    = 3'd6,
    OP_CANCEL      = 3'd7
  } opcode_t;

  state_t                 state, state_n;
  opcode_t                opcode;
  logic [28:0]            cmd_val;
  logic                   cmd_avail, take, trig_raw, do_trig, cancel_take;
  logic                   all_waiting, ext_trig_q, lockout_ok, wr_busy;
  logic [N_DAC-1:0]       dac_mask;
  logic [N_ADC-1:0]       adc_mask;
  logic [28:0]            remaining, delay_cnt, lockout_cnt, lockout_val;
  logic [TIMER_WIDTH-1:0] trig_timer;
  logic                   timer_run, hi_pending;
  logic [31:0]            hi_word;

  assign opcode      = opcode_t'(cmd_word[31:29]);
  assign cmd_val     = cmd_word[28:0];
  assign cmd_avail   = !cmd_buf_empty;
  assign lockout_ok  = cmd_val >= 29'(LOCKOUT_MIN);
  assign wr_busy     = data_word_wr_en | hi_pending;
  // Masked-off channels count as waiting, so all-zero masks make this constantly true.
  assign all_waiting = (&(dac_waiting_for_trig | ~dac_mask)) &
                       (&(adc_waiting_for_trig | ~adc_mask));

`ifdef SHIM_TRIG_EDGE_DETECT_EN
  logic ext_trig_d;
  always_ff @(posedge clk) begin
    if (!resetn) ext_trig_d <= 1'b0;
    else         ext_trig_d <= ext_trig;
  end
  assign ext_trig_q = ext_trig & ~ext_trig_d;
`else
  assign ext_trig_q = ext_trig;
`endif

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_n  = state;
    take     = 1'b0;
    trig_raw = 1'b0;
    case (state)
      ST_IDLE: take = cmd_avail;
      ST_SYNC: begin
        if (all_waiting) begin
          trig_raw = 1'b1;
          state_n  = ST_IDLE;
          take     = cmd_avail;
        end
      end
      ST_EXPECT: begin
        if (remaining == '0) begin
          state_n = ST_IDLE;
          take    = cmd_avail;
        end else if (lockout_cnt == '0 && ext_trig_q) begin
          trig_raw = 1'b1;
          if (remaining == 29'd1) state_n = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (delay_cnt == '0) begin
          state_n = ST_IDLE;
          take    = cmd_avail;
        end
      end
      default: ;
    endcase

    if (state != ST_ERROR && cmd_avail && opcode == OP_CANCEL) take = 1'b1;

    if (take) begin
      case (opcode)
        OP_CANCEL, OP_SET_MASK: state_n = ST_IDLE;
        OP_FORCE_TRIG: begin
          trig_raw = 1'b1;
          state_n  = ST_IDLE;
        end
        OP_SET_LOCKOUT: state_n = lockout_ok ? ST_IDLE : ST_ERROR;
        OP_SYNC_CH: begin
          if (all_waiting) begin
            trig_raw = 1'b1;
            state_n  = ST_IDLE;
          end else begin
            state_n  = ST_SYNC;
          end
        end
        OP_EXPECT_EXT: state_n = (cmd_val == '0) ? ST_IDLE : ST_EXPECT;
        OP_DELAY:      state_n = (cmd_val == '0) ? ST_IDLE : ST_DELAY;
        default:       state_n = ST_ERROR;
      endcase
    end
  end

  assign cancel_take    = take && opcode == OP_CANCEL;
  assign do_trig        = trig_raw && !cancel_take;
  assign cmd_word_rd_en = take && resetn;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= ST_IDLE;
      trig_out          <= 1'b0;
      trig_count        <= '0;
      bad_cmd           <= 1'b0;
      data_buf_overflow <= 1'b0;
      data_word_wr_en   <= 1'b0;
      data_word         <= '0;
      hi_word           <= '0;
      hi_pending        <= 1'b0;
      remaining         <= '0;
      delay_cnt         <= '0;
      lockout_cnt       <= '0;
      lockout_val       <= 29'(LOCKOUT_DEFAULT);
      dac_mask          <= '1;
      adc_mask          <= '1;
      trig_timer        <= '0;
      timer_run         <= 1'b0;
    end else begin
      state    <= state_n;
      trig_out <= do_trig && (state_n != ST_ERROR);
      if (do_trig)             trig_count <= trig_count + 32'd1;
      if (state_n == ST_ERROR) bad_cmd    <= 1'b1;

      if (take && opcode == OP_SET_MASK) begin
        dac_mask <= cmd_val[N_DAC-1:0];
        adc_mask <= cmd_val[8 +: N_ADC];
      end
      if (take && opcode == OP_SET_LOCKOUT && lockout_ok) lockout_val <= cmd_val;

      if (cancel_take)                                  remaining <= '0;
      else if (take && opcode == OP_EXPECT_EXT)         remaining <= cmd_val;
      else if (state == ST_EXPECT && do_trig)           remaining <= remaining - 29'd1;

      // Loading val-1 makes DELAY of N spend exactly N cycles in ST_DELAY.
      if (cancel_take)                                          delay_cnt <= '0;
      else if (take && opcode == OP_DELAY && cmd_val != '0)     delay_cnt <= cmd_val - 29'd1;
      else if (state == ST_DELAY && delay_cnt != '0)            delay_cnt <= delay_cnt - 29'd1;

      if (state == ST_EXPECT && do_trig) lockout_cnt <= lockout_val;
      else if (lockout_cnt != '0)        lockout_cnt <= lockout_cnt - 29'd1;

      if (timer_run || do_trig) begin
        timer_run <= 1'b1;
        if (trig_timer != '1) trig_timer <= trig_timer + 1'b1;
      end

      if (hi_pending) begin
        data_word_wr_en <= 1'b1;
        data_word       <= hi_word;
        hi_pending      <= 1'b0;
      end else if (do_trig && !wr_busy && !data_buf_full && !data_buf_almost_full) begin
        data_word_wr_en <= 1'b1;
        data_word       <= trig_timer[31:0];
        hi_word         <= 32'(trig_timer >> 32);
        hi_pending      <= 1'b1;
      end else begin
        data_word_wr_en <= 1'b0;
      end

      if (do_trig && (data_buf_full || data_buf_almost_full)) data_buf_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shim_trigger_seq.sv
// Scoreboard bench for shim_trigger_seq: directed command sequences, expected trigger pulses and
// timestamp words are queued by the stimulus and matched by a negedge monitor.
module tb_shim_trigger_seq;
  localparam int N_DAC = 8;
  localparam int N_ADC = 8;
  localparam int TW    = 40;

  localparam logic [2:0] OP_SYNC_CH     = 3'd1;
  localparam logic [2:0] OP_SET_LOCKOUT = 3'd2;
  localparam logic [2:0] OP_EXPECT_EXT  = 3'd3;
  localparam logic [2:0] OP_DELAY       = 3'd4;
  localparam logic [2:0] OP_FORCE_TRIG  = 3'd5;
  localparam logic [2:0] OP_SET_MASK    = 3'd6;
  localparam logic [2:0] OP_CANCEL      = 3'd7;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_word_rd_en;
  logic [31:0]      cmd_word = '0;
  logic             cmd_buf_empty = 1'b1;
  logic             data_word_wr_en;
  logic [31:0]      data_word;
  logic             data_buf_full = 1'b0;
  logic             data_buf_almost_full = 1'b0;
  logic             ext_trig = 1'b0;
  logic [N_DAC-1:0] dac_waiting_for_trig = '0;
  logic [N_ADC-1:0] adc_waiting_for_trig = '0;
  logic             trig_out;
  logic [31:0]      trig_count;
  logic             data_buf_overflow;
  logic             bad_cmd;

  shim_trigger_seq #(
    .N_DAC(N_DAC), .N_ADC(N_ADC), .TIMER_WIDTH(TW),
    .LOCKOUT_DEFAULT(5000), .LOCKOUT_MIN(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_word_rd_en(cmd_word_rd_en), .cmd_word(cmd_word), .cmd_buf_empty(cmd_buf_empty),
    .data_word_wr_en(data_word_wr_en), .data_word(data_word),
    .data_buf_full(data_buf_full), .data_buf_almost_full(data_buf_almost_full),
    .ext_trig(ext_trig),
    .dac_waiting_for_trig(dac_waiting_for_trig), .adc_waiting_for_trig(adc_waiting_for_trig),
    .trig_out(trig_out), .trig_count(trig_count),
    .data_buf_overflow(data_buf_overflow), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t        trig_q[$];
  exp_t        data_q[$];
  exp_t        log_q[$];
  logic [31:0] cmd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          take_seen = 1'b0;
  int          t0 = -1;
  int          last_w = -100;
  int          exp_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic push_cmd(input logic [2:0] op, input int val);
    cmd_q.push_back({op, 29'(val)});
  endtask

  // Model of trigger side effects: pulse/count one cycle later, timestamp words when the buffer has room
  // and no two-word write occupies the cycles after an earlier accepted trigger.
  task automatic expect_trig(input int t, input bit buf_ok);
    int tv;
    exp_count++;
    trig_q.push_back('{t + 1, 32'(exp_count)});
    if (t0 < 0) begin
      t0 = t;
      tv = 0;
    end else begin
      tv = t - t0;
    end
    if (buf_ok && t > last_w + 2) begin
      data_q.push_back('{t + 1, 32'(tv)});
      data_q.push_back('{t + 2, 32'h0});
      last_w = t;
    end
  endtask

  task automatic wait_consume(input logic [2:0] op, input int budget, output int c);
    exp_t e;
    c = -1;
    for (int i = 0; i < budget && log_q.size() == 0; i++) next_cycle();
    if (log_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL consume_timeout: actual none within %0d cycles required opcode %0d", budget, op);
    end else begin
      e = log_q.pop_front();
      c = e.cyc;
      check("consume_opcode", 64'(e.val[31:29]), 64'(op));
    end
  endtask

  // Command FIFO model: presents the queue head, pops after the DUT reads it.
  initial forever begin
    @(posedge clk);
    #1;
    if (take_seen && cmd_q.size() > 0) void'(cmd_q.pop_front());
    cmd_buf_empty = (cmd_q.size() == 0);
    cmd_word      = (cmd_q.size() > 0) ? cmd_q[0] : 32'h0;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    take_seen = cmd_word_rd_en;
    if (cmd_word_rd_en) log_q.push_back('{cyc, cmd_word});
    if (trig_out) begin
      if (trig_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trig_unexpected: actual trig_out=1 at cycle %0d required no pulse", cyc);
      end else begin
        e = trig_q.pop_front();
        check("trig_cycle", 64'(cyc), 64'(e.cyc));
        check("trig_count", 64'(trig_count), 64'(e.val));
      end
    end
    if (data_word_wr_en) begin
      if (data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_unexpected: actual write %0h at cycle %0d required no write", data_word, cyc);
      end else begin
        e = data_q.pop_front();
        check("data_cycle", 64'(cyc), 64'(e.cyc));
        check("data_word", 64'(data_word), 64'(e.val));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, c, c2, l, d, f, f2, k, e;

    // Reset state; a queued command must not be read while resetn is low.
    dac_waiting_for_trig = 8'h03;
    adc_waiting_for_trig = 8'h01;
    push_cmd(OP_SET_MASK, 32'h0000_0103);
    push_cmd(OP_SYNC_CH, 0);
    repeat (3) next_cycle();
    check("rst_rd_en", 64'(cmd_word_rd_en), 64'd0);
    check("rst_trig_out", 64'(trig_out), 64'd0);
    check("rst_trig_count", 64'(trig_count), 64'd0);
    check("rst_wr_en", 64'(data_word_wr_en), 64'd0);
    check("rst_data_word", 64'(data_word), 64'd0);
    check("rst_overflow", 64'(data_buf_overflow), 64'd0);
    check("rst_bad_cmd", 64'(bad_cmd), 64'd0);
    resetn = 1'b1;

    // Masked sync: only DAC0/DAC1/ADC0 enabled and waiting.
    wait_consume(OP_SET_MASK, 10, r);
    wait_consume(OP_SYNC_CH, 10, c);
    check("sync_after_mask", 64'(c), 64'(r + 1));
    expect_trig(c, 1'b1);

    // SYNC_CH while DAC1 not ready waits in SYNC until it becomes ready.
    dac_waiting_for_trig = 8'h01;
    push_cmd(OP_SYNC_CH, 0);
    wait_consume(OP_SYNC_CH, 10, c);
    repeat (5) next_cycle();
    dac_waiting_for_trig = 8'h03;
    expect_trig(cyc, 1'b1);

    // Level ext_trig with lockout 10: two triggers 11 cycles apart, then back to IDLE.
    ext_trig = 1'b1;
    push_cmd(OP_SET_LOCKOUT, 10);
    push_cmd(OP_EXPECT_EXT, 2);
    wait_consume(OP_SET_LOCKOUT, 10, l);
    wait_consume(OP_EXPECT_EXT, 10, c);
    check("expect_after_lockout", 64'(c), 64'(l + 1));
    expect_trig(c + 1, 1'b1);
    expect_trig(c + 12, 1'b1);
    while (cyc < c + 30) next_cycle();
    k = cyc;
    push_cmd(OP_FORCE_TRIG, 0);
    wait_consume(OP_FORCE_TRIG, 10, f);
    check("idle_after_expect", 64'(f), 64'(k + 1));
    expect_trig(f, 1'b1);
    ext_trig = 1'b0;

    // DELAY 100 holds the next command for exactly 100 cycles.
    push_cmd(OP_DELAY, 100);
    push_cmd(OP_FORCE_TRIG, 0);
    wait_consume(OP_DELAY, 10, d);
    wait_consume(OP_FORCE_TRIG, 150, f);
    check("delay_100_gap", 64'(f - d), 64'd100);
    expect_trig(f, 1'b1);

    // CANCEL mid-delay is taken at once and returns to IDLE.
    push_cmd(OP_DELAY, 50);
    wait_consume(OP_DELAY, 10, d);
    repeat (10) next_cycle();
    k = cyc;
    push_cmd(OP_CANCEL, 0);
    push_cmd(OP_FORCE_TRIG, 0);
    wait_consume(OP_CANCEL, 10, c);
    check("cancel_immediate", 64'(c), 64'(k + 1));
    wait_consume(OP_FORCE_TRIG, 10, f);
    check("idle_after_cancel", 64'(f), 64'(k + 2));
    expect_trig(f, 1'b1);

    // Almost-full and full: pulse still issued, no write, sticky overflow.
    data_buf_almost_full = 1'b1;
    push_cmd(OP_FORCE_TRIG, 0);
    wait_consume(OP_FORCE_TRIG, 10, f);
    expect_trig(f, 1'b0);
    next_cycle();
    check("overflow_set", 64'(data_buf_overflow), 64'd1);
    data_buf_almost_full = 1'b0;
    data_buf_full = 1'b1;
    push_cmd(OP_FORCE_TRIG, 0);
    wait_consume(OP_FORCE_TRIG, 10, f);
    expect_trig(f, 1'b0);
    next_cycle();
    data_buf_full = 1'b0;

    // Back-to-back triggers: second one lands during the two-word write and logs nothing.
    push_cmd(OP_FORCE_TRIG, 0);
    push_cmd(OP_FORCE_TRIG, 0);
    wait_consume(OP_FORCE_TRIG, 10, f);
    expect_trig(f, 1'b1);
    wait_consume(OP_FORCE_TRIG, 10, f2);
    check("force_back_to_back", 64'(f2), 64'(f + 1));
    expect_trig(f2, 1'b1);
    repeat (4) next_cycle();
    check("overflow_sticky", 64'(data_buf_overflow), 64'd1);

    // Lockout below minimum: ERROR, sticky bad_cmd, CANCEL ignored.
    push_cmd(OP_SET_LOCKOUT, 3);
    wait_consume(OP_SET_LOCKOUT, 10, e);
    check("bad_cmd_set", 64'(bad_cmd), 64'd1);
    push_cmd(OP_CANCEL, 0);
    push_cmd(OP_FORCE_TRIG, 0);
    repeat (10) next_cycle();
    check("error_no_consume", 64'(log_q.size()), 64'd0);
    check("error_rd_en", 64'(cmd_word_rd_en), 64'd0);
    check("bad_cmd_sticky", 64'(bad_cmd), 64'd1);

    // Reset leaves ERROR and clears sticky flags and counters.
    resetn = 1'b0;
    cmd_q.delete();
    repeat (2) next_cycle();
    log_q.delete();
    t0 = -1;
    last_w = -100;
    exp_count = 0;
    check("rst2_bad_cmd", 64'(bad_cmd), 64'd0);
    check("rst2_overflow", 64'(data_buf_overflow), 64'd0);
    check("rst2_trig_count", 64'(trig_count), 64'd0);
    resetn = 1'b1;

    // Reset during a two-word write: low word appears, high word never does.
    push_cmd(OP_FORCE_TRIG, 0);
    wait_consume(OP_FORCE_TRIG, 10, f);
    expect_trig(f, 1'b1);
    void'(data_q.pop_back());
    resetn = 1'b0;
    repeat (3) next_cycle();
    check("abort_wr_en", 64'(data_word_wr_en), 64'd0);
    check("abort_trig_count", 64'(trig_count), 64'd0);
    resetn = 1'b1;
    repeat (5) next_cycle();
    check("trig_q_drained", 64'(trig_q.size()), 64'd0);
    check("data_q_drained", 64'(data_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
